// File: rtl/mem_access_pkg.sv
// Shared encodings for the MEM-stage data-memory access unit.
// Access codes, FSM states and the access-code decode helpers.
package mem_access_pkg;

  localparam logic [3:0] RW_NONE = 4'b0000;
  localparam logic [3:0] RW_SB   = 4'b0001;
  localparam logic [3:0] RW_SH   = 4'b0010;
  localparam logic [3:0] RW_SW   = 4'b0011;
  localparam logic [3:0] RW_LB   = 4'b1000;
  localparam logic [3:0] RW_LH   = 4'b1001;
  localparam logic [3:0] RW_LW   = 4'b1010;
  localparam logic [3:0] RW_LBU  = 4'b1100;
  localparam logic [3:0] RW_LHU  = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } size_t;

  typedef struct packed {
    logic  valid;
    logic  load;
    logic  store;
    logic  sign;
    size_t size;
  } acc_dec_t;

  function automatic acc_dec_t decode_rw(input logic [3:0] rw);
    acc_dec_t d;
    d = '0;
    d.size = SZ_W;
    case (rw)
      RW_SB:  begin d.store = 1'b1; d.size = SZ_B; end
      RW_SH:  begin d.store = 1'b1; d.size = SZ_H; end
      RW_SW:  begin d.store = 1'b1; d.size = SZ_W; end
      RW_LB:  begin d.load = 1'b1; d.size = SZ_B; d.sign = 1'b1; end
      RW_LH:  begin d.load = 1'b1; d.size = SZ_H; d.sign = 1'b1; end
      RW_LW:  begin d.load = 1'b1; d.size = SZ_W; end
      RW_LBU: begin d.load = 1'b1; d.size = SZ_B; end
      RW_LHU: begin d.load = 1'b1; d.size = SZ_H; end
      default: ;
    endcase
    d.valid = d.load | d.store;
    return d;
  endfunction

  // Natural alignment of the low address bits for a given size.
  function automatic logic [1:0] align_lo(
    input logic [1:0] lo,
    input size_t      sz
  );
    case (sz)
      SZ_B:    return lo;
      SZ_H:    return {lo[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_data_extender.sv
// Byte/half lane select from a memory word plus sign or zero extension.
// Purely combinational; shared with any future cache read path.
module load_data_extender
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  size_t       size,
  input  logic        sign,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata[{addr_lo, 3'b000} +: 8];
    h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    unique case (size)
      SZ_B:    data = {{24{sign & b[7]}}, b};
      SZ_H:    data = {{16{sign & h[15]}}, h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory controller: request/busywait handshake and load align.
// MEM_MISALIGN_TRAP_EN: flag misaligned half/word accesses instead of aligning.
module mem_access_unit
  import mem_access_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] IN_ALU_RESULT,
  input  logic [31:0] IN_DATA2,
  input  logic [3:0]  IN_READ_WRITE,
  output logic        BUSYWAIT,
  output logic [31:0] OUT_LOAD_DATA,
  output logic        OUT_MISALIGNED,
  output logic [31:0] MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  output logic [3:0]  MEM_BYTE_EN,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT
);

  acc_dec_t    dec;
  logic [1:0]  addr_lo;
  logic        valid;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] ext;
  state_t      state_q;
  state_t      state_d;
  logic        ld_q;
  logic        sign_q;
  size_t       size_q;
  logic [1:0]  lo_q;

  assign dec     = decode_rw(IN_READ_WRITE);
  assign addr_lo = align_lo(IN_ALU_RESULT[1:0], dec.size);

`ifdef MEM_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned     = dec.valid & (addr_lo != IN_ALU_RESULT[1:0]);
  assign valid          = dec.valid & ~misaligned;
  assign OUT_MISALIGNED = misaligned & RESET;
`else
  assign valid          = dec.valid;
  assign OUT_MISALIGNED = 1'b0;
`endif

  assign BUSYWAIT = RESET & valid & (state_q != ST_DONE);

  always_comb begin
    be    = 4'b0000;
    wdata = IN_DATA2;
    if (dec.store) begin
      unique case (dec.size)
        SZ_B: begin
          be    = 4'b0001 << addr_lo;
          wdata = {4{IN_DATA2[7:0]}};
        end
        SZ_H: begin
          be    = 4'b0011 << {addr_lo[1], 1'b0};
          wdata = {2{IN_DATA2[15:0]}};
        end
        default: be = 4'b1111;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (valid) state_d = ST_ACCESS;
      ST_ACCESS: if (!MEM_BUSYWAIT) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  load_data_extender u_ext (
    .rdata   (MEM_READDATA),
    .addr_lo (lo_q),
    .size    (size_q),
    .sign    (sign_q),
    .data    (ext)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q       <= ST_IDLE;
      MEM_READ      <= 1'b0;
      MEM_WRITE     <= 1'b0;
      MEM_ADDRESS   <= '0;
      MEM_WRITEDATA <= '0;
      MEM_BYTE_EN   <= '0;
      OUT_LOAD_DATA <= '0;
      ld_q          <= 1'b0;
      sign_q        <= 1'b0;
      size_q        <= SZ_W;
      lo_q          <= 2'b00;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && valid) begin
        MEM_READ      <= dec.load;
        MEM_WRITE     <= dec.store;
        MEM_ADDRESS   <= {IN_ALU_RESULT[31:2], 2'b00};
        MEM_WRITEDATA <= wdata;
        MEM_BYTE_EN   <= be;
        ld_q          <= dec.load;
        sign_q        <= dec.sign;
        size_q        <= dec.size;
        lo_q          <= addr_lo;
      end else if (state_q == ST_ACCESS && !MEM_BUSYWAIT) begin
        MEM_READ  <= 1'b0;
        MEM_WRITE <= 1'b0;
        if (ld_q) OUT_LOAD_DATA <= ext;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus random traffic
// checked against a byte-addressed reference memory.
module tb_mem_access_unit;

  logic        CLK;
  logic        RESET;
  logic [31:0] IN_ALU_RESULT;
  logic [31:0] IN_DATA2;
  logic [3:0]  IN_READ_WRITE;
  logic        BUSYWAIT;
  logic [31:0] OUT_LOAD_DATA;
  logic        OUT_MISALIGNED;
  logic [31:0] MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [3:0]  MEM_BYTE_EN;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;

  mem_access_unit dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .IN_ALU_RESULT  (IN_ALU_RESULT),
    .IN_DATA2       (IN_DATA2),
    .IN_READ_WRITE  (IN_READ_WRITE),
    .BUSYWAIT       (BUSYWAIT),
    .OUT_LOAD_DATA  (OUT_LOAD_DATA),
    .OUT_MISALIGNED (OUT_MISALIGNED),
    .MEM_ADDRESS    (MEM_ADDRESS),
    .MEM_WRITEDATA  (MEM_WRITEDATA),
    .MEM_BYTE_EN    (MEM_BYTE_EN),
    .MEM_READ       (MEM_READ),
    .MEM_WRITE      (MEM_WRITE),
    .MEM_READDATA   (MEM_READDATA),
    .MEM_BUSYWAIT   (MEM_BUSYWAIT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;
  logic [7:0]  ref_mem [0:1023];
  logic [31:0] dev [0:255];
  logic [31:0] last_ld = 32'h0;

  function automatic void check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endfunction

  task automatic preload(input int a, input logic [31:0] w);
    dev[a >> 2] = w;
    for (int i = 0; i < 4; i++) ref_mem[(a & ~3) + i] = w[8*i +: 8];
  endtask

  // Drive one access starting just after a rising edge; returns likewise.
  task automatic run_acc(input logic [3:0] rw, input logic [31:0] addr,
                         input logic [31:0] data, input int waits);
    int sz, ea, stall, reqc;
    bit ld, st, sgn, trap, done;
    logic [63:0] v;
    logic [31:0] exp_be, exp_wd, exp_ld;
    sz = 4; ld = 0; st = 0; sgn = 0; trap = 0;
    case (rw)
      4'b0001: begin st = 1; sz = 1; end
      4'b0010: begin st = 1; sz = 2; end
      4'b0011: begin st = 1; sz = 4; end
      4'b1000: begin ld = 1; sz = 1; sgn = 1; end
      4'b1001: begin ld = 1; sz = 2; sgn = 1; end
      4'b1010: begin ld = 1; sz = 4; end
      4'b1100: begin ld = 1; sz = 1; end
      4'b1101: begin ld = 1; sz = 2; end
      default: ;
    endcase
    ea = int'(addr);
    if ((ld || st) && (ea % sz != 0)) begin
`ifdef MEM_MISALIGN_TRAP_EN
      trap = 1;
`else
      ea = ea - (ea % sz);
`endif
    end
    exp_be = ((32'd1 << sz) - 1) << (ea % 4);
    exp_wd = (sz == 1) ? data[7:0] * 32'h01010101 :
             (sz == 2) ? data[15:0] * 32'h00010001 : data;
    v = 64'd0;
    for (int i = 0; i < sz; i++) v = v | (64'(ref_mem[ea + i]) << (8 * i));
    if (sgn && v[8*sz-1]) v = v | ~((64'd1 << (8 * sz)) - 1);
    exp_ld = v[31:0];

    IN_ALU_RESULT = addr;
    IN_DATA2 = data;
    IN_READ_WRITE = rw;
    MEM_BUSYWAIT = 1'b0;
    if (!(ld || st) || trap) begin
      #1;
      check("pass_busywait", BUSYWAIT, 0);
      check("pass_misaligned", OUT_MISALIGNED, trap);
      @(posedge CLK); #1;
      check("pass_noreq", {MEM_READ, MEM_WRITE}, 0);
      check("pass_loaddata", OUT_LOAD_DATA, last_ld);
      return;
    end
    stall = 0; reqc = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge CLK);
      if (!BUSYWAIT) done = 1;
      else begin
        stall++;
        if (MEM_READ || MEM_WRITE) begin
          reqc++;
          if (reqc == 1) begin
            check("req_addr", MEM_ADDRESS, addr & ~32'd3);
            check("req_rd", MEM_READ, ld);
            check("req_wr", MEM_WRITE, st);
            if (st) begin
              check("req_be", MEM_BYTE_EN, exp_be);
              check("req_wdata", MEM_WRITEDATA, exp_wd);
            end
          end
          MEM_READDATA = dev[MEM_ADDRESS[9:2]];
          MEM_BUSYWAIT = (reqc <= waits) ? 1'b1 : 1'b0;
          if (!MEM_BUSYWAIT && MEM_WRITE)
            for (int i = 0; i < 4; i++)
              if (MEM_BYTE_EN[i])
                dev[MEM_ADDRESS[9:2]][8*i +: 8] = MEM_WRITEDATA[8*i +: 8];
        end
      end
    end
    check("done_reached", done, 1);
    check("stall_cycles", stall, 2 + waits);
    check("req_cycles", reqc, 1 + waits);
    check("done_noreq", {MEM_READ, MEM_WRITE}, 0);
    if (ld) last_ld = exp_ld;
    check("load_data", OUT_LOAD_DATA, last_ld);
    if (st) for (int i = 0; i < sz; i++) ref_mem[ea + i] = data[8*i +: 8];
    @(posedge CLK); #1;
    MEM_BUSYWAIT = 1'b0;
  endtask

  initial begin
    logic [3:0] codes [0:10];
    codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b1000, 4'b1001,
              4'b1010, 4'b1100, 4'b1101, 4'b0111, 4'b1111};
    RESET = 1'b0;
    IN_ALU_RESULT = '0;
    IN_DATA2 = '0;
    IN_READ_WRITE = 4'b0000;
    MEM_READDATA = '0;
    MEM_BUSYWAIT = 1'b0;
    for (int i = 0; i < 256; i++) preload(i * 4, $urandom);
    #2;
    check("rst_busywait", BUSYWAIT, 0);
    check("rst_req", {MEM_READ, MEM_WRITE}, 0);
    check("rst_addr", MEM_ADDRESS, 0);
    check("rst_be", MEM_BYTE_EN, 0);
    check("rst_wdata", MEM_WRITEDATA, 0);
    check("rst_load", OUT_LOAD_DATA, 0);
    check("rst_mis", OUT_MISALIGNED, 0);
    @(posedge CLK); #1;
    RESET = 1'b1;
    @(posedge CLK); #1;

    run_acc(4'b0011, 32'h100, 32'hDEADBEEF, 0);
    preload(32'h100, 32'h80FF7F01);
    run_acc(4'b1000, 32'h103, 32'h0, 0);
    check("lb_value", OUT_LOAD_DATA, 32'hFFFFFF80);
    run_acc(4'b1100, 32'h103, 32'h0, 1);
    check("lbu_value", OUT_LOAD_DATA, 32'h00000080);
    preload(32'h100, 32'h8001ABCD);
    run_acc(4'b1001, 32'h102, 32'h0, 3);
    check("lh_value", OUT_LOAD_DATA, 32'hFFFF8001);
    run_acc(4'b0001, 32'h0A1, 32'h000000AB, 0);
    run_acc(4'b1010, 32'h0A0, 32'h0, 0);
    run_acc(4'b0000, 32'h0A0, 32'h0, 0);
    run_acc(4'b1010, 32'h102, 32'h0, 0);

    // Reset in the second ACCESS cycle of a long-waiting LW.
    IN_ALU_RESULT = 32'h200;
    IN_READ_WRITE = 4'b1010;
    MEM_BUSYWAIT = 1'b1;
    repeat (3) @(negedge CLK);
    check("abort_pre_rd", MEM_READ, 1);
    RESET = 1'b0;
    #1;
    check("abort_rd", MEM_READ, 0);
    check("abort_wr", MEM_WRITE, 0);
    check("abort_busy", BUSYWAIT, 0);
    check("abort_be", MEM_BYTE_EN, 0);
    check("abort_load", OUT_LOAD_DATA, 0);
    last_ld = 32'h0;
    IN_READ_WRITE = 4'b0000;
    @(posedge CLK); #1;
    RESET = 1'b1;
    MEM_BUSYWAIT = 1'b0;
    run_acc(4'b1010, 32'h200, 32'h0, 1);

    for (int n = 0; n < 60; n++)
      run_acc(codes[$urandom_range(0, 10)], 32'($urandom_range(0, 1023)),
              $urandom, int'($urandom_range(0, 3)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

- MEM-stage data-memory access controller.
- Sits directly downstream of the EX/MEM pipeline register.
- Takes the registered address, store data and 4-bit access code, and runs a request/busywait handshake with the data memory.
- Stalls the whole pipeline through `BUSYWAIT`, and presents byte-aligned, sign- or zero-extended load data to the MEM/WB register.

## Interface
Parameters:
- None; all encodings come from the shared package.

Ports:
- `CLK`  in  1  clock; all state changes on the rising edge.
- `RESET`  in  1  asynchronous, active-low reset.
- `IN_ALU_RESULT`  in  32  byte address, from EX/MEM `OUT_ALU_RESULT`.
- `IN_DATA2`  in  32  store data, from EX/MEM `OUT_DATA2`.
- `IN_READ_WRITE`  in  4  access code, from EX/MEM `OUT_READ_WRITE`.
- `BUSYWAIT`  out  1  pipeline stall; all pipeline registers hold while it is 1.
- `OUT_LOAD_DATA`  out  32  aligned and extended load result.
- `OUT_MISALIGNED`  out  1  misaligned-access flag (see Configuration).
- `MEM_ADDRESS`  out  32  word address to memory; bits [1:0] are always 0.
- `MEM_WRITEDATA`  out  32  store data, lane-replicated.
- `MEM_BYTE_EN`  out  4  byte lanes for stores.
- `MEM_READ`  out  1  read request.
- `MEM_WRITE`  out  1  write request.
- `MEM_READDATA`  in  32  read data from memory.
- `MEM_BUSYWAIT`  in  1  memory not ready.

## Operation
Access codes:
- 0000: no access.
- 0001: SB.  0010: SH.  0011: SW.
- 1000: LB.  1001: LH.  1010: LW.
- 1100: LBU.  1101: LHU.
- Any other code is treated as no access.

State machine (`IDLE`, `ACCESS`, `DONE`):
- `IDLE`: on a valid aligned access, latch address, data, code and lanes; go to `ACCESS`.
- `ACCESS`: `MEM_READ` or `MEM_WRITE` is held from registered state. At an edge with `MEM_BUSYWAIT`=0, capture `MEM_READDATA` and go to `DONE`.
- `DONE`: `BUSYWAIT`=0 for exactly one cycle. The pipeline advances at the next edge, and the state returns to `IDLE`.

`BUSYWAIT` (combinational):
- Equals (valid access) AND (state != `DONE`).
- Forced to 0 while `RESET` is low.
- A no-access code gives `BUSYWAIT`=0 with no state change (zero-latency pass-through).

Load data:
- Selected by address bits [1:0].
- Byte loads use lane = addr[1:0]; half loads use lane = addr[1].
- Sign-extended for LB/LH, zero-extended for LBU/LHU.
- `OUT_LOAD_DATA` holds its value until the next load completes.

Stores:
- `MEM_WRITEDATA`: byte data replicated ×4, half data replicated ×2, word passed through.
- `MEM_BYTE_EN` per store size: SB = 0001 << addr[1:0]; SH = 0011 << addr[1]×2; SW = 1111.

Reset (asynchronous, active-low):
- Applies at any time, including mid-`ACCESS`.
- State goes to `IDLE`; `MEM_READ`, `MEM_WRITE`, `BUSYWAIT` and `OUT_MISALIGNED` go to 0; `MEM_BYTE_EN`=0; `OUT_LOAD_DATA`, `MEM_ADDRESS` and `MEM_WRITEDATA` go to 0.
- An aborted access is not retried. The memory sees its request drop.

## Timing
- Valid access arriving after edge N, with a zero-wait memory:
  - edge N+1: `IDLE`→`ACCESS`
  - edge N+2: `ACCESS`→`DONE`
  - edge N+3: the pipeline advances.
- Stall is therefore 2 cycles minimum; each cycle of `MEM_BUSYWAIT`=1 in `ACCESS` adds one cycle.
- Request outputs are registered and stable for the whole of `ACCESS`; they deassert on the edge into `DONE`.
- `OUT_LOAD_DATA` is valid throughout `DONE`, and is sampled by MEM/WB at the `DONE`→`IDLE` edge.
- Back-to-back accesses: the next instruction is seen in `IDLE` one cycle after `DONE`, so there is no re-issue of the completed access.

## Configuration
`MEM_MISALIGN_TRAP_EN`:
- Defined:
  - Misaligned halfword (addr[0]=1) or word (addr[1:0]≠0) access: no memory request, state stays `IDLE`, `BUSYWAIT`=0.
  - `OUT_MISALIGNED`=1 combinationally for that cycle.
  - Load data is unchanged.
- Undefined:
  - `OUT_MISALIGNED` is tied 0.
  - Offending low address bits are forced to natural alignment and the access proceeds.

## Structure
- Package `mem_access_pkg`:
  - access-code constants (`RW_NONE`, `RW_SB` … `RW_LHU`)
  - state encoding (`ST_IDLE`, `ST_ACCESS`, `ST_DONE`)
  - size/extension decode helper.
- Sub-module `load_data_extender`: combinational lane select plus sign/zero extension, reused by any future cache path.

## Test plan
- SW at 0x100 with data 0xDEADBEEF and zero-wait memory → `MEM_WRITE`=1 for 1 cycle, `MEM_BYTE_EN`=1111, `BUSYWAIT`=1 for exactly 2 cycles.
- LB at 0x103 with memory word 0x80FF7F01 → `OUT_LOAD_DATA`=0xFFFFFF80; the same address with LBU → 0x00000080.
- LH at 0x102 with `MEM_BUSYWAIT` held 3 extra cycles, memory word 0x8001ABCD → `BUSYWAIT` high for 5 cycles, `OUT_LOAD_DATA`=0xFFFF8001.
- SB at 0x0A1 with data 0x000000AB → `MEM_BYTE_EN`=0010, `MEM_WRITEDATA`=0xABABABAB, `MEM_ADDRESS`=0x0A0.
- `RESET` driven low during the 2nd cycle of `ACCESS` → `MEM_READ`, `MEM_WRITE` and `BUSYWAIT` go to 0 immediately; after release, the state is `IDLE` and a new LW completes normally.
- With `MEM_MISALIGN_TRAP_EN` defined, LW at 0x102 → `OUT_MISALIGNED`=1, no `MEM_READ`, `BUSYWAIT`=0.
